// File: rtl/pc_fetch_sequencer.sv
// Next-PC and hold control for the program-counter register: boot vector, sequential
// fetch, branch/jump redirects, hazard stalls, imem wait with timeout, and halt.
module pc_fetch_sequencer #(
  parameter int PC_W        = 8,
  parameter int RESET_VEC   = 0,
  parameter int INC         = 1,
  parameter int BOOT_CYCLES = 2,
  parameter int MAX_WAIT    = 15
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_cur,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            stall_req,
  input  logic            imem_ready,
  input  logic            halt_req,
  input  logic            resume,
  output logic [31:0]     pc_next,
  output logic            pc_hold,
  output logic            fetch_valid,
  output logic [1:0]      fsm_state,
  output logic            timeout_err
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int BW = $clog2(BOOT_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [PC_W-1:0] VEC   = PC_W'(RESET_VEC);
  localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

  state_t          state;
  logic [BW-1:0]   boot_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            pending_valid;
  logic [PC_W-1:0] pending_target;

  logic            accept;
  logic            advance;
  logic [PC_W-1:0] sel_pc;
  logic [PC_W-1:0] next_pc;

  assign fsm_state = state;
  assign pc_next   = 32'(next_pc);

  // WAIT with imem_ready behaves exactly like an accepting FETCH cycle.
  always_comb begin
    accept      = ((state == ST_FETCH) || (state == ST_WAIT)) && imem_ready;
    advance     = accept && !halt_req && !stall_req;
    sel_pc      = pc_cur + INC_V;
    if (pending_valid) sel_pc = pending_target;
    if (branch_taken)  sel_pc = branch_target;
    if (jump)          sel_pc = jump_target;
    next_pc     = pc_cur;
    pc_hold     = 1'b1;
    fetch_valid = 1'b0;
    if (!reset) begin
      next_pc = VEC;
    end else if (state == ST_BOOT) begin
      next_pc = VEC;
      pc_hold = 1'b0;
    end else begin
      fetch_valid = accept;
      pc_hold     = !advance;
      if (advance) next_pc = sel_pc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_BOOT;
      boot_cnt       <= '0;
      wait_cnt       <= '0;
      pending_valid  <= 1'b0;
      pending_target <= '0;
      timeout_err    <= 1'b0;
    end else begin
      // Redirects seen while the PC is held are parked; any advance consumes them.
      if (pc_hold && (jump || branch_taken)) begin
        pending_valid  <= 1'b1;
        pending_target <= jump ? jump_target : branch_target;
      end else if (advance) begin
        pending_valid  <= 1'b0;
      end

      case (state)
        ST_BOOT: begin
          if (boot_cnt == BW'(BOOT_CYCLES - 1)) begin
            boot_cnt <= '0;
            state    <= ST_FETCH;
          end else begin
            boot_cnt <= boot_cnt + BW'(1);
          end
        end
        ST_FETCH: begin
          if (!imem_ready) begin
            if (MAX_WAIT <= 1) begin
              timeout_err <= 1'b1;
              state       <= ST_HALT;
            end else begin
              wait_cnt <= WW'(1);
              state    <= ST_WAIT;
            end
          end else if (halt_req) begin
            state <= ST_HALT;
          end
        end
        ST_WAIT: begin
          if (imem_ready) begin
            wait_cnt <= '0;
            state    <= halt_req ? ST_HALT : ST_FETCH;
          end else if (wait_cnt >= WW'(MAX_WAIT - 1)) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b1;
            state       <= ST_HALT;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        ST_HALT: begin
          if (resume) state <= ST_FETCH;
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: a cycle-by-cycle vector table plus
// hand-written timeout and reset-in-HALT sequences.
module tb_pc_fetch_sequencer;

  logic        clock;
  logic        reset;
  logic [7:0]  pc_cur;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        jump;
  logic [7:0]  jump_target;
  logic        stall_req;
  logic        imem_ready;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc_next;
  logic        pc_hold;
  logic        fetch_valid;
  logic [1:0]  fsm_state;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] pc;
    logic       br;
    logic [7:0] bt;
    logic       jmp;
    logic [7:0] jt;
    logic       stall;
    logic       ready;
    logic       halt;
    logic       res;
    logic       chk_next;
    logic [7:0] exp_next;
    logic       exp_hold;
    logic       exp_fv;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[$];

  pc_fetch_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .pc_cur        (pc_cur),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .stall_req     (stall_req),
    .imem_ready    (imem_ready),
    .halt_req      (halt_req),
    .resume        (resume),
    .pc_next       (pc_next),
    .pc_hold       (pc_hold),
    .fetch_valid   (fetch_valid),
    .fsm_state     (fsm_state),
    .timeout_err   (timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: act=running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(string name, logic [7:0] pc, logic br, logic [7:0] bt,
                              logic jmp, logic [7:0] jt, logic stall, logic ready,
                              logic halt, logic res, logic chk_next, logic [7:0] exp_next,
                              logic exp_hold, logic exp_fv, logic [1:0] exp_state);
    vec_t v;
    v.name = name; v.pc = pc; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
    v.stall = stall; v.ready = ready; v.halt = halt; v.res = res;
    v.chk_next = chk_next; v.exp_next = exp_next; v.exp_hold = exp_hold;
    v.exp_fv = exp_fv; v.exp_state = exp_state;
    return v;
  endfunction

  task automatic cmp(string name, string field, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: act=0x%0h exp=0x%0h", name, field, act, exp);
    end
  endtask

  task automatic applyStimulus(logic [7:0] pc, logic br, logic [7:0] bt, logic jmp,
                               logic [7:0] jt, logic stall, logic ready, logic halt,
                               logic res);
    pc_cur = pc; branch_taken = br; branch_target = bt; jump = jmp; jump_target = jt;
    stall_req = stall; imem_ready = ready; halt_req = halt; resume = res;
  endtask

  task automatic checkOutput(string name, logic chk_next, logic [31:0] exp_next,
                             logic exp_hold, logic exp_fv, logic [1:0] exp_state,
                             logic exp_to);
    if (chk_next) cmp(name, "pc_next", pc_next, exp_next);
    cmp(name, "pc_hold", 32'(pc_hold), 32'(exp_hold));
    cmp(name, "fetch_valid", 32'(fetch_valid), 32'(exp_fv));
    cmp(name, "fsm_state", 32'(fsm_state), 32'(exp_state));
    cmp(name, "timeout_err", 32'(timeout_err), 32'(exp_to));
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // name pc br bt jmp jt stall ready halt res | chk next hold fv state
    vecs.push_back(mk("boot0",     8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 8'h00, 0, 0, 2'd0));
    vecs.push_back(mk("boot1",     8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 8'h00, 0, 0, 2'd0));
    vecs.push_back(mk("seq0",      8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 8'h01, 0, 1, 2'd1));
    vecs.push_back(mk("seq1",      8'h01, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 8'h02, 0, 1, 2'd1));
    vecs.push_back(mk("seq2",      8'h02, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 8'h03, 0, 1, 2'd1));
    vecs.push_back(mk("jmp_vs_br", 8'h10, 1, 8'h20, 1, 8'h40, 0, 1, 0, 0, 1, 8'h40, 0, 1, 2'd1));
    vecs.push_back(mk("stall1_br", 8'h40, 1, 8'h33, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 1, 1, 2'd1));
    vecs.push_back(mk("stall2",    8'h40, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 1, 1, 2'd1));
    vecs.push_back(mk("stall3",    8'h40, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 1, 1, 2'd1));
    vecs.push_back(mk("pend_apply",8'h40, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 8'h33, 0, 1, 2'd1));
    vecs.push_back(mk("pend_clr",  8'h33, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 8'h34, 0, 1, 2'd1));
    vecs.push_back(mk("wrap",      8'hFF, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 8'h00, 0, 1, 2'd1));
    vecs.push_back(mk("miss_jmp",  8'h00, 0, 8'h00, 1, 8'h80, 0, 0, 0, 0, 0, 8'h00, 1, 0, 2'd1));
    vecs.push_back(mk("wait1",     8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 0, 2'd2));
    vecs.push_back(mk("wait_rdy",  8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 8'h80, 0, 1, 2'd2));
    vecs.push_back(mk("after_wait",8'h80, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 8'h81, 0, 1, 2'd1));
    vecs.push_back(mk("halt_req",  8'h81, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00, 1, 1, 2'd1));
    vecs.push_back(mk("halt_br",   8'h81, 1, 8'h55, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00, 1, 0, 2'd3));
    vecs.push_back(mk("resume",    8'h81, 0, 8'h00, 0, 8'h00, 1, 1, 0, 1, 0, 8'h00, 1, 0, 2'd3));
    vecs.push_back(mk("halt_pend", 8'h81, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 8'h55, 0, 1, 2'd1));
    vecs.push_back(mk("stall_both",8'h55, 1, 8'h22, 1, 8'h11, 1, 1, 0, 0, 0, 8'h00, 1, 1, 2'd1));
    vecs.push_back(mk("stall_ovr", 8'h55, 1, 8'h66, 0, 8'h00, 1, 1, 0, 0, 0, 8'h00, 1, 1, 2'd1));
    vecs.push_back(mk("ovr_apply", 8'h55, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 8'h66, 0, 1, 2'd1));
    vecs.push_back(mk("miss2",     8'h66, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 1, 0, 2'd1));
    vecs.push_back(mk("wait_halt", 8'h66, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00, 1, 1, 2'd2));
    vecs.push_back(mk("resume2",   8'h66, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1, 0, 8'h00, 1, 0, 2'd3));
    vecs.push_back(mk("post_res",  8'h66, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 8'h67, 0, 1, 2'd1));

    reset = 1'b0;
    applyStimulus(8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
    #2;
    checkOutput("in_reset", 1, 32'h0, 1, 0, 2'd0, 0);
    nextCycle();
    checkOutput("in_reset_edge", 1, 32'h0, 1, 0, 2'd0, 0);
    reset = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].pc, vecs[i].br, vecs[i].bt, vecs[i].jmp, vecs[i].jt,
                    vecs[i].stall, vecs[i].ready, vecs[i].halt, vecs[i].res);
      @(negedge clock);
      checkOutput(vecs[i].name, vecs[i].chk_next, 32'(vecs[i].exp_next), vecs[i].exp_hold,
                  vecs[i].exp_fv, vecs[i].exp_state, 0);
      nextCycle();
    end

    // 15 consecutive imem misses from FETCH end in HALT with the sticky timeout flag.
    for (int i = 1; i <= 15; i++) begin
      applyStimulus(8'h67, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
      @(negedge clock);
      checkOutput($sformatf("miss_%0d", i), 0, 32'h0, 1, 0, (i == 1) ? 2'd1 : 2'd2, 0);
      nextCycle();
    end
    applyStimulus(8'h67, 0, 8'h00, 0, 8'h00, 0, 1, 0, 1);
    @(negedge clock);
    checkOutput("timeout_halt", 0, 32'h0, 1, 0, 2'd3, 1);
    nextCycle();
    applyStimulus(8'h67, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
    @(negedge clock);
    checkOutput("timeout_resumed", 1, 32'h68, 0, 1, 2'd1, 1);
    nextCycle();

    // Halt, park a jump in HALT, then reset: state and flag clear at once, jump discarded.
    applyStimulus(8'h68, 0, 8'h00, 0, 8'h00, 0, 1, 1, 0);
    @(negedge clock);
    checkOutput("halt2_req", 0, 32'h0, 1, 1, 2'd1, 1);
    nextCycle();
    applyStimulus(8'h68, 0, 8'h00, 1, 8'h99, 0, 1, 0, 0);
    @(negedge clock);
    checkOutput("halt2_jmp", 0, 32'h0, 1, 0, 2'd3, 1);
    nextCycle();
    applyStimulus(8'h68, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
    @(negedge clock);
    checkOutput("halt2_hold", 0, 32'h0, 1, 0, 2'd3, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset", 1, 32'h0, 1, 0, 2'd0, 0);
    nextCycle();
    reset = 1'b1;
    applyStimulus(8'h00, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0);
    @(negedge clock);
    checkOutput("reboot0", 1, 32'h0, 0, 0, 2'd0, 0);
    nextCycle();
    @(negedge clock);
    checkOutput("reboot1", 1, 32'h0, 0, 0, 2'd0, 0);
    nextCycle();
    @(negedge clock);
    checkOutput("reboot_fetch", 1, 32'h1, 0, 1, 2'd1, 0);
    nextCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
